// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory and IF/ID bundle of the fetch stage
interface pc_fetch_unit_if #(
    parameter int NB_PC    = 32,
    parameter int NB_INSTR = 32
);
    logic [NB_PC-1:0]    o_imem_addr;
    logic [NB_INSTR-1:0] i_imem_data;
    logic [NB_INSTR-1:0] o_if_id_instr;
    logic [NB_PC-1:0]    o_if_id_pc;
    logic [NB_PC-1:0]    o_if_id_pc4;
    logic                o_if_id_valid;

    modport master (
        output o_imem_addr,
        input  i_imem_data,
        output o_if_id_instr,
        output o_if_id_pc,
        output o_if_id_pc4,
        output o_if_id_valid
    );

    modport slave (
        input  o_imem_addr,
        output i_imem_data,
        input  o_if_id_instr,
        input  o_if_id_pc,
        input  o_if_id_pc4,
        input  o_if_id_valid
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, IF/ID register and run/drain/halt sequencing
module pc_fetch_unit #(
    parameter int                   NB_PC        = 32,
    parameter int                   NB_INSTR     = 32,
    parameter logic [NB_PC-1:0]     RESET_PC     = '0,
    parameter logic [NB_INSTR-1:0]  HALT_INSTR   = 32'hFFFFFFFF,
    parameter int                   DRAIN_CYCLES = 4
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_start,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic [1:0]         i_pcSrc,
    input  logic [NB_PC-1:0]   i_branch_target,
    input  logic [NB_PC-1:0]   i_jalr_target,
    pc_fetch_unit_if.master    bus,
    output logic               o_halted,
    output logic [1:0]         o_state
);
    localparam int NB_CNT = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [NB_CNT-1:0]   CNT_INIT = NB_CNT'(DRAIN_CYCLES - 1);
    localparam logic [NB_INSTR-1:0] NOP      = NB_INSTR'(32'h00000013);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_DRAIN  = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    state_t              state_q, state_nxt;
    logic [NB_CNT-1:0]   cnt_q, cnt_nxt;
    logic [NB_PC-1:0]    pc_q, pc_nxt, pc_plus4, redirect_pc;
    logic [NB_INSTR-1:0] instr_q, instr_nxt;
    logic [NB_PC-1:0]    ifpc_q, ifpc_nxt, ifpc4_q, ifpc4_nxt;
    logic                valid_q, valid_nxt;
    logic                halted_q;

    assign pc_plus4 = pc_q + NB_PC'(4);

    // Redirect target for a flush; reserved select falls back to sequential fetch.
    always_comb begin
        case (i_pcSrc)
            2'b01:   redirect_pc = i_branch_target;
            2'b10:   redirect_pc = i_jalr_target & ~NB_PC'(1);
            default: redirect_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        ifpc_nxt  = ifpc_q;
        ifpc4_nxt = ifpc4_q;
        valid_nxt = valid_q;

        if (i_en) begin
            case (state_q)
                S_IDLE: begin
                    pc_nxt    = RESET_PC;
                    instr_nxt = NOP;
                    ifpc_nxt  = '0;
                    ifpc4_nxt = '0;
                    valid_nxt = 1'b0;
                    if (i_start) state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (i_flush) begin
                        pc_nxt    = redirect_pc;
                        instr_nxt = NOP;
                        ifpc_nxt  = '0;
                        ifpc4_nxt = '0;
                        valid_nxt = 1'b0;
                    end else if (i_stall) begin
                        pc_nxt = pc_q;
                    end else if (bus.i_imem_data == HALT_INSTR) begin
                        // The halt word itself never enters the pipeline.
                        instr_nxt = NOP;
                        ifpc_nxt  = '0;
                        ifpc4_nxt = '0;
                        valid_nxt = 1'b0;
                        state_nxt = S_DRAIN;
                        cnt_nxt   = CNT_INIT;
                    end else begin
                        pc_nxt    = pc_plus4;
                        instr_nxt = bus.i_imem_data;
                        ifpc_nxt  = pc_q;
                        ifpc4_nxt = pc_plus4;
                        valid_nxt = 1'b1;
                    end
                end
                S_DRAIN: begin
                    instr_nxt = NOP;
                    ifpc_nxt  = '0;
                    ifpc4_nxt = '0;
                    valid_nxt = 1'b0;
                    if (i_flush) begin
                        // An older branch resolved taken: the halt was on a wrong path.
                        pc_nxt    = redirect_pc;
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end else if (!i_stall) begin
                        if (cnt_q == '0) state_nxt = S_HALTED;
                        else             cnt_nxt   = cnt_q - NB_CNT'(1);
                    end
                end
                default: begin
                    state_nxt = S_HALTED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pc_q     <= RESET_PC;
            instr_q  <= NOP;
            ifpc_q   <= '0;
            ifpc4_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            pc_q     <= pc_nxt;
            instr_q  <= instr_nxt;
            ifpc_q   <= ifpc_nxt;
            ifpc4_q  <= ifpc4_nxt;
            valid_q  <= valid_nxt;
            halted_q <= (state_nxt == S_HALTED);
        end
    end

    assign bus.o_imem_addr   = pc_q;
    assign bus.o_if_id_instr = instr_q;
    assign bus.o_if_id_pc    = ifpc_q;
    assign bus.o_if_id_pc4   = ifpc4_q;
    assign bus.o_if_id_valid = valid_q;
    assign o_halted          = halted_q;
    assign o_state           = state_q;
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage that sits directly downstream of the branch control unit.
- Consumes the PC-source select and flush outputs and the EX-stage branch/JALR targets, and owns the PC register.
- Drives the instruction-memory address and the IF/ID pipeline register.
- Contains a small run/drain/halt FSM so the debug unit can start the core and detect program end.

Parameters:
- NB_PC, 32, PC and target width.
- NB_INSTR, 32, instruction width.
- RESET_PC, 0, PC value after reset and in IDLE.
- HALT_INSTR, 32'hFFFFFFFF, encoding that ends the program.
- DRAIN_CYCLES, 4, cycles to let in-flight instructions retire after a halt is fetched (minimum 1).

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_en, in, 1, global enable from the debug unit (run/step); 0 freezes all state.
- i_start, in, 1, start pulse, sampled in IDLE only.
- i_stall, in, 1, load-use stall from the hazard unit.
- i_flush, in, 1, flush from the branch control unit.
- i_pcSrc, in, 2, next-PC select: 00 PC+4, 01 branch/JAL target, 10 JALR target, 11 reserved.
- i_branch_target, in, NB_PC, PC+imm from EX.
- i_jalr_target, in, NB_PC, rs1+imm from EX.
- i_imem_data, in, NB_INSTR, instruction at o_imem_addr (combinational read, same cycle).
- o_imem_addr, out, NB_PC, current PC.
- o_if_id_instr, out, NB_INSTR, IF/ID instruction.
- o_if_id_pc, out, NB_PC, IF/ID PC.
- o_if_id_pc4, out, NB_PC, IF/ID PC+4 (link value).
- o_if_id_valid, out, 1, IF/ID holds a real instruction.
- o_halted, out, 1, program finished and pipeline drained.
- o_state, out, 2, FSM state: 00 IDLE, 01 RUN, 10 DRAIN, 11 HALTED.

Behaviour:
- Reset (asynchronous, any time, including mid-run): PC=RESET_PC, o_if_id_instr=32'h00000013 (NOP), o_if_id_pc=0, o_if_id_pc4=0, o_if_id_valid=0, o_halted=0, state=IDLE, drain counter=0.
- Bubble means IF/ID instr=NOP, pc=0, pc4=0, valid=0.
- i_en=0: PC, IF/ID, FSM and counter all hold, regardless of other inputs.
- The rules below assume i_en=1.
- IDLE:
  - PC held at RESET_PC; IF/ID loads a bubble.
  - i_start=1 -> RUN next cycle.
  - The first fetch occurs in the first RUN cycle.
- RUN, evaluated in priority order:
  1. i_flush=1:
     - pcSrc 01 -> PC<=i_branch_target.
     - pcSrc 10 -> PC<=i_jalr_target with bit0 cleared.
     - pcSrc 00 or 11 -> PC<=PC+4.
     - IF/ID<=bubble.
     - Flush overrides i_stall and any HALT_INSTR currently fetched.
  2. i_stall=1: PC and IF/ID hold.
  3. i_imem_data==HALT_INSTR:
     - PC holds; IF/ID<=bubble (halt is never forwarded).
     - state<=DRAIN; counter<=DRAIN_CYCLES-1.
  4. Otherwise:
     - PC<=PC+4.
     - IF/ID<={i_imem_data, PC, PC+4}, valid=1.
  - pcSrc without flush is ignored (sequential fetch).
- DRAIN:
  - PC holds; IF/ID<=bubble every cycle.
  - i_flush=1 (an older branch resolved taken): redirect PC as in RUN, state<=RUN, counter cleared.
  - Else if i_stall=0: the counter decrements; when the counter is 0, state<=HALTED instead.
  - Else (i_stall=1): the counter holds.
- HALTED:
  - o_halted=1 (registered, asserted in the same cycle the state becomes HALTED).
  - PC holds; IF/ID holds the bubble.
  - Flush, stall and start are ignored.
  - Only reset exits this state.
- Arithmetic:
  - PC+4 wraps modulo 2^NB_PC (0xFFFFFFFC -> 0x00000000).
  - Targets are used unmodified except for the JALR bit0 clear.
  - No misalignment trap.
- o_imem_addr always equals the PC register; no combinational path from i_flush or i_pcSrc to o_imem_addr.

Test Plan:
- Reset -> i_start pulse; imem returns 0x00500093 at 0 and 0x00A00113 at 4 -> PC 0,4,8 on consecutive RUN cycles; IF/ID shows pc=0/pc4=4/instr=0x00500093/valid=1, then pc=4.
- PC=0x10, i_flush=1, pcSrc=01, branch_target=0x40 -> next PC=0x40; IF/ID instr=0x13, valid=0. Repeat with pcSrc=10, jalr_target=0x123 -> PC=0x122.
- i_stall high for 2 cycles at PC=0x8 -> PC and IF/ID unchanged for 2 cycles, then PC=0xC. Stall and flush in the same cycle (target 0x80) -> PC=0x80, bubble.
- HALT_INSTR fetched at PC=0x20 -> PC stays 0x20, state DRAIN for 4 cycles, then HALTED with o_halted=1. Repeat with a 1-cycle stall in DRAIN -> HALTED one cycle later.
- HALT at 0x20, then i_flush with pcSrc=01 and target 0x60 in the second DRAIN cycle -> state RUN, PC=0x60, fetch resumes, o_halted stays 0.
- i_en=0 for 3 cycles mid-RUN -> all outputs frozen. Async i_rst_n low mid-cycle in RUN -> outputs take reset values immediately, state IDLE.
- PC=0xFFFFFFFC, no stall or flush -> PC wraps to 0x00000000.
